// File: rtl/uart_tx.sv
// uart_tx: UART serializer. Sends one start bit, DATA_WIDTH data bits LSB-first,
// an optional parity bit and one stop bit for each accepted byte.
// Build option: define UART_TX_PRESCALE_EN to build the per-bit prescale counter.
// Without it, every state lasts one CLK cycle and CLK is the bit clock.
//
// state    | meaning
// S_IDLE   | line high, waiting for Data_Valid
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only when latched PAR_EN = 1)
// S_STOP   | stop bit (high)
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int scaler_width = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   P_DATA,
  input  logic                    Data_Valid,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  input  logic [scaler_width-1:0] Prescale,
  output logic                    TX_OUT,
  output logic                    busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    accept;
  logic                    bit_tick;

  // A request is taken only when no frame is in flight; anything else is dropped.
  assign accept = (state_q == S_IDLE) && Data_Valid;

`ifdef UART_TX_PRESCALE_EN
  logic [scaler_width-1:0] presc_q;
  logic [scaler_width-1:0] presc_cnt_q, presc_cnt_d;
  logic [scaler_width-1:0] presc_term;

  // Prescale of 0 behaves as 1, so the terminal count saturates at 0.
  assign presc_term = (presc_q == '0) ? '0 : (presc_q - scaler_width'(1));
  assign bit_tick   = (presc_cnt_q == presc_term);

  // Cycle counter within a bit period; restarts on every bit/state change.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (state_q == S_IDLE || bit_tick) begin
      presc_cnt_d = '0;
    end else begin
      presc_cnt_d = presc_cnt_q + scaler_width'(1);
    end
  end

  // Prescale latch and cycle counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      if (accept) begin
        presc_q <= Prescale;
      end
    end
  end
`else
  logic unused_prescale;

  // Each state lasts exactly one CLK cycle; Prescale is not used.
  assign bit_tick        = 1'b1;
  assign unused_prescale = ^Prescale;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (Data_Valid) state_d = S_START;
      S_START:  if (bit_tick) state_d = S_DATA;
      S_DATA:   if (bit_tick && bit_cnt_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP:   if (bit_tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Data bit index; only advances inside S_DATA and is 0 everywhere else.
  always_comb begin
    bit_cnt_d = '0;
    if (state_q == S_DATA) begin
      if (bit_tick) begin
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : (bit_cnt_q + CNT_W'(1));
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end
  end

  // Bit counter and frame parameters latched on accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  // Output decode from the current state; registered below, so the line
  // trails the state by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_q)
      S_IDLE:   begin tx_d = 1'b1; busy_d = 1'b0; end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_cnt_q];
      S_PARITY: tx_d = (^data_q) ^ par_typ_q;
      S_STOP:   tx_d = 1'b1;
      default:  begin tx_d = 1'b1; busy_d = 1'b0; end
    endcase
  end

  // Registered line and busy outputs; reset forces an idle line at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Expected bit streams are pushed to a queue when a
// byte is sent and popped bit by bit while the line is sampled on negedges.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int SW = 5;
`ifdef UART_TX_PRESCALE_EN
  localparam bit HAS_PS = 1'b1;
`else
  localparam bit HAS_PS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [SW-1:0] Prescale;
  logic          TX_OUT;
  logic          busy;

  int checks = 0;
  int passed = 0;
  bit exp_q[$];

  uart_tx #(.DATA_WIDTH(DW), .scaler_width(SW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic int p_eff(input int p);
    if (!HAS_PS) return 1;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ pt);
    exp_q.push_back(1'b1);
  endtask

  // Presents one byte for a single accept edge, then scrambles the inputs.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input int p);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = SW'(p); Data_Valid = 1'b1;
    push_frame(d, pe, pt);
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA = DW'($urandom);
    PAR_EN = ~pe;
    PAR_TYP = ~pt;
    Prescale = SW'($urandom);
  endtask

  // Scoreboard consumer: every bit must hold for p cycles with busy high.
  task automatic drain(input int nbits, input int p, input string name);
    for (int b = 0; b < nbits; b++) begin
      bit   e;
      bit   bad;
      logic got_tx;
      logic got_busy;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL %s bit %0d: scoreboard empty, expected a queued bit", name, b);
        return;
      end
      e = exp_q.pop_front();
      bad = 1'b0; got_tx = 1'b0; got_busy = 1'b0;
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (!bad && (TX_OUT !== e || busy !== 1'b1)) begin
          bad = 1'b1; got_tx = TX_OUT; got_busy = busy;
        end
      end
      checks++;
      if (bad) $display("FAIL %s bit %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1",
                        name, b, got_tx, got_busy, e);
      else passed++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = '0;
    #12;
    checks++;
    if (TX_OUT !== 1'b1) $display("FAIL reset_tx: TX_OUT=%b, expected 1", TX_OUT); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b, expected 0", busy); else passed++;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic idle_check(input int n, input string name);
    bit   bad = 1'b0;
    logic gt = 1'b1;
    logic gb = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      if (!bad && (TX_OUT !== 1'b1 || busy !== 1'b0)) begin
        bad = 1'b1; gt = TX_OUT; gb = busy;
      end
    end
    checks++;
    if (bad) $display("FAIL %s: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", name, gt, gb);
    else passed++;
  endtask

  task automatic test_parity_even();
    int p = p_eff(16);
    send(8'hA5, 1'b1, 1'b0, 16);
    drain(11, p, "a5_even");
    idle_check(3, "a5_even_idle");
  endtask

  task automatic test_no_parity();
    int p = p_eff(8);
    send(8'hFF, 1'b0, 1'b0, 8);
    drain(10, p, "ff_nopar");
    idle_check(3, "ff_nopar_idle");
  endtask

  task automatic test_parity_odd();
    int p = p_eff(8);
    send(8'h00, 1'b1, 1'b1, 8);
    drain(11, p, "00_odd");
    idle_check(3, "00_odd_idle");
  endtask

  task automatic test_back_to_back();
    int p = p_eff(16);
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = SW'(16); Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    push_frame(8'hC3, 1'b0, 1'b0);
    @(negedge CLK);
    P_DATA = 8'hC3;
    drain(10, p, "b2b_first");
    // single idle cycle between stop bit and next start bit
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_gap: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    else passed++;
    Data_Valid = 1'b0;
    fork
      begin
        repeat (3 * p + 1) @(negedge CLK);
        P_DATA = 8'h55; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
      end
    join_none
    drain(10, p, "b2b_second");
    idle_check(3 * p + 2, "b2b_pulse_dropped");
  endtask

  task automatic test_reset_mid_frame();
    int p = p_eff(16);
    send(8'h5A, 1'b0, 1'b0, 16);
    repeat (3 * p + 1) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0)
      $display("FAIL async_reset: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    else passed++;
    exp_q.delete();
    RST = 1'b1;
    idle_check(2 * p + 20, "post_reset_idle");
    send(8'h96, 1'b1, 1'b0, 8);
    drain(11, p_eff(8), "post_reset_frame");
    idle_check(2, "post_reset_frame_idle");
  endtask

  task automatic test_prescale_edge();
    int praw;
`ifdef UART_TX_PRESCALE_EN
    praw = 0;
`else
    praw = 16;
`endif
    send(8'h81, 1'b0, 1'b0, praw);
    drain(10, p_eff(praw), "81_prescale_edge");
    idle_check(3, "81_idle");
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_no_parity();
    test_parity_odd();
    test_back_to_back();
    test_reset_mid_frame();
    test_prescale_edge();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serializer that sits directly upstream of the UART receiver and drives its `RX_IN` line. Accepts a parallel byte with a one-cycle valid strobe, then emits one start bit, `DATA_WIDTH` data bits LSB-first, an optional parity bit and one stop bit. It serves as the on-chip stimulus source for the receiver's environment and as the TX half of the full UART.

## Interface
- `DATA_WIDTH`, 8, payload width in bits.
- `scaler_width`, 5, width of `Prescale`.
- `CLK` input 1, single clock; all logic on rising edge.
- `RST` input 1, reset, asynchronous, active-low.
- `P_DATA` input `DATA_WIDTH`, byte to send; sampled on accept.
- `Data_Valid` input 1, request strobe; accepted only while `busy`=0.
- `PAR_EN` input 1, 1 = parity bit inserted; sampled on accept.
- `PAR_TYP` input 1, 0 = even, 1 = odd; sampled on accept.
- `Prescale` input `scaler_width`, CLK cycles per bit; sampled on accept.
- `TX_OUT` output 1, serial line, idle high, registered.
- `busy` output 1, high for the duration of a frame, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `busy`=0. On a rising edge with `Data_Valid`=1, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`, then go to START.
- START: `TX_OUT`=0 for one bit period, then go to DATA.
- DATA: shift out latched data LSB-first, one bit per period; a bit counter runs 0..`DATA_WIDTH`-1. After the last bit go to PARITY if latched `PAR_EN`=1, else go to STOP.
- PARITY: `TX_OUT` = XOR-reduce(latched data) XOR latched `PAR_TYP`.
- STOP: `TX_OUT`=1 for one bit period, then go to IDLE.
- `Data_Valid` while `busy`=1 is ignored: no queueing, no effect on the frame in flight.
- Input changes after accept do not affect the current frame.
- Reset (any time, including mid-frame): `TX_OUT`=1, `busy`=0, state IDLE, counters 0, latched data 0. An aborted frame is not resumed.

## Timing
- Reset values: `TX_OUT`=1, `busy`=0.
- Accept at edge k: `TX_OUT` falls and `busy` rises at edge k+1 (latency of 1 cycle).
- Bit period P = latched `Prescale` CLK cycles; `Prescale`=0 is treated as 1.
- Frame length: (`DATA_WIDTH`+2+`PAR_EN`)·P cycles. `busy` is high for exactly that many cycles and falls at the same edge `TX_OUT` leaves the stop bit (it is already 1).
- Back-to-back: if `Data_Valid` is held high, the next accept happens at the first edge with `busy`=0. The line is therefore high for exactly 1 cycle between a stop bit's period and the next start bit, giving P+1 cycles of high.
- The bit counter and prescale counter wrap to 0 on every bit/state transition. Counters never exceed their terminal value.

## Configuration
- `UART_TX_PRESCALE_EN` defined: internal prescale counter built in; bit period = latched `Prescale` cycles of `CLK`. This lets TX share the receiver's oversampling clock.
- Not defined: no prescale counter; P is fixed at 1 and each state lasts one `CLK` cycle. In this mode `CLK` is the bit-rate TX clock (16× the receiver clock period). `Prescale` is ignored but the port remains.

## Test plan
- With macro, P=16, `PAR_EN`=1, `PAR_TYP`=0, `P_DATA`=0xA5 -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit 16 cycles; `busy` high 176 cycles.
- P=8, `PAR_EN`=0, `P_DATA`=0xFF -> 0 then eight 1s then stop 1; `busy` high 80 cycles; no parity bit.
- P=8, `PAR_EN`=1, `PAR_TYP`=1, `P_DATA`=0x00 -> parity bit 1; looped into the receiver, it yields `P_DATA`=0x00 with `data_valid` asserted.
- `Data_Valid` held high with 0x3C then 0xC3, P=16 -> two complete frames, exactly 17 high cycles between the end of the first stop-bit start and the second start bit; a pulse of 0x55 issued mid-frame is dropped.
- Assert `RST` low in the middle of DATA of 0x5A -> `TX_OUT`=1 and `busy`=0 immediately (no clock edge needed). After release, the line stays idle high until a new `Data_Valid`.
- Macro undefined, `P_DATA`=0x81, `PAR_EN`=0 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1; `Prescale` value has no effect.
